// File: rtl/fft_pkg.sv
// fft_pkg: shared defaults and state type for the fftfull frame loader.
package fft_pkg;
  localparam int BIT_WIDTH_D = 16;
  localparam int N_D = 9;
  localparam int FFT_SIZE_D = 512;
  localparam int ADC_WIDTH_D = 12;
  typedef enum logic [1:0] {CAPTURE, BURST, START} loader_state_t;
endpackage

// File: rtl/fft_frame_loader_if.sv
// fft_frame_loader_if: ADC capture inputs and fftfull load/start handshake.
interface fft_frame_loader_if #(
  parameter int BIT_WIDTH = fft_pkg::BIT_WIDTH_D,
  parameter int N = fft_pkg::N_D,
  parameter int ADC_WIDTH = fft_pkg::ADC_WIDTH_D
) ();
  logic en;
  logic adc_valid;
  logic [ADC_WIDTH-1:0] adc_data;
  logic noted;
  logic fft_load;
  logic [N-1:0] add_rd;
  logic [BIT_WIDTH-1:0] din;
  logic fft_start;
  logic busy;
  logic overrun;
  modport master (
    input en, adc_valid, adc_data, noted,
    output fft_load, add_rd, din, fft_start, busy, overrun
  );
  modport slave (
    output en, adc_valid, adc_data, noted,
    input fft_load, add_rd, din, fft_start, busy, overrun
  );
endinterface

// File: rtl/fft_frame_loader_frame_ram.sv
// frame_ram: simple dual-port RAM, sync write, sync read with 1-cycle latency.
module frame_ram #(
  parameter int W = 16,
  parameter int D = 512,
  parameter int A = 9
) (
  input  logic         clk,
  input  logic         i_we,
  input  logic [A-1:0] i_waddr,
  input  logic [W-1:0] i_wdata,
  input  logic [A-1:0] i_raddr,
  output logic [W-1:0] o_rdata
);
  logic [W-1:0] r_mem [D];
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/fft_frame_loader.sv
// fft_frame_loader: buffers one ADC frame, bursts it into fftfull, then holds fft_start until noted.
module fft_frame_loader
  import fft_pkg::*;
#(
  parameter int BIT_WIDTH = BIT_WIDTH_D,
  parameter int N = N_D,
  parameter int FFT_SIZE = FFT_SIZE_D,
  parameter int ADC_WIDTH = ADC_WIDTH_D
) (
  input logic clk,
  input logic reset,
  fft_frame_loader_if.master bus
);
  loader_state_t r_state;
  logic [N-1:0] r_wptr, r_ra, r_ra_d, r_add_rd;
  logic r_issue, r_issue_d, r_fft_load, r_fft_start, r_busy, r_overrun;
  logic [BIT_WIDTH-1:0] r_din, w_rdata, w_ext, w_conv;
  logic [ADC_WIDTH-1:0] w_s;
  logic w_we, w_last_beat;
  // Offset-binary to two's complement is an MSB flip; then sign-extend and scale up.
  assign w_s = {~bus.adc_data[ADC_WIDTH-1], bus.adc_data[ADC_WIDTH-2:0]};
  assign w_ext = {{(BIT_WIDTH-ADC_WIDTH){w_s[ADC_WIDTH-1]}}, w_s};
  assign w_conv = w_ext << (BIT_WIDTH-ADC_WIDTH-1);
  assign w_we = (r_state == CAPTURE) && bus.en && bus.adc_valid;
  assign w_last_beat = r_fft_load && (r_add_rd == N'(FFT_SIZE-1));
  frame_ram #(.W(BIT_WIDTH), .D(FFT_SIZE), .A(N)) u_ram (
    .clk(clk),
    .i_we(w_we),
    .i_waddr(r_wptr),
    .i_wdata(w_conv),
    .i_raddr(r_ra),
    .o_rdata(w_rdata)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= CAPTURE;
      r_wptr <= '0;
      r_ra <= '0;
      r_ra_d <= '0;
      r_issue <= 1'b0;
      r_issue_d <= 1'b0;
      r_fft_load <= 1'b0;
      r_add_rd <= '0;
      r_din <= '0;
      r_fft_start <= 1'b0;
      r_busy <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      // Read address and RAM data travel one stage together so add_rd and din stay aligned.
      r_ra_d <= r_ra;
      r_issue_d <= r_issue;
      r_fft_load <= r_issue_d;
      r_add_rd <= r_ra_d;
      r_din <= w_rdata;
      if (r_state != CAPTURE && bus.adc_valid) r_overrun <= 1'b1;
      if (r_state == CAPTURE) begin
        if (w_we) begin
          r_wptr <= r_wptr + 1'b1;
          if (r_wptr == N'(FFT_SIZE-1)) begin
            r_state <= BURST;
            r_busy <= 1'b1;
            r_issue <= 1'b1;
            r_ra <= '0;
          end
        end
      end else if (r_state == BURST) begin
        if (r_issue) begin
          r_ra <= r_ra + 1'b1;
          if (r_ra == N'(FFT_SIZE-1)) r_issue <= 1'b0;
        end
        if (w_last_beat) begin
          r_state <= START;
          r_fft_start <= 1'b1;
        end
      end else if (bus.noted) begin
        r_state <= CAPTURE;
        r_fft_start <= 1'b0;
        r_busy <= 1'b0;
        r_wptr <= '0;
      end
    end
  end
  assign bus.fft_load = r_fft_load;
  assign bus.add_rd = r_add_rd;
  assign bus.din = r_din;
  assign bus.fft_start = r_fft_start;
  assign bus.busy = r_busy;
  assign bus.overrun = r_overrun;
endmodule

// File: tb/tb_fft_frame_loader.sv
// tb_fft_frame_loader: directed scenario tasks for the frame loader.
module tb_fft_frame_loader;
  localparam int BW = 16;
  localparam int NW = 9;
  localparam int FS = 512;
  localparam int AW = 12;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_checks = 0;
  int n_pass = 0;
  logic [BW-1:0] exp_q [FS];
  fft_frame_loader_if #(.BIT_WIDTH(BW), .N(NW), .ADC_WIDTH(AW)) bus ();
  fft_frame_loader #(.BIT_WIDTH(BW), .N(NW), .FFT_SIZE(FS), .ADC_WIDTH(AW)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;

  function automatic logic [BW-1:0] conv(input int a);
    int s;
    s = a - 2048;
    return BW'(s * 8);
  endfunction

  task automatic send(input int d, input logic e);
    @(negedge clk);
    bus.en = e;
    bus.adc_valid = 1'b1;
    bus.adc_data = AW'(d);
    @(negedge clk);
    bus.adc_valid = 1'b0;
  endtask

  task automatic capture_ramp(input int base);
    for (int k = 0; k < FS; k++) begin
      exp_q[k] = conv(base + k);
      send(base + k, 1'b1);
    end
  endtask

  task automatic check_burst(input string name, input bit inject);
    int wait_n, bad, first_k;
    logic [NW-1:0] first_a;
    logic [BW-1:0] first_d;
    wait_n = 0;
    bad = 0;
    first_k = -1;
    first_a = '0;
    first_d = '0;
    while (bus.fft_load !== 1'b1 && wait_n < 50) begin
      @(negedge clk);
      wait_n++;
    end
    n_checks++;
    if (wait_n >= 50) begin
      $display("FAIL %s_burst_start: fft_load=%b after %0d cycles, required 1", name, bus.fft_load, wait_n);
      return;
    end
    n_pass++;
    for (int k = 0; k < FS; k++) begin
      if (bus.fft_load !== 1'b1 || bus.add_rd !== NW'(k) || bus.din !== exp_q[k]) begin
        bad++;
        if (first_k < 0) begin
          first_k = k;
          first_a = bus.add_rd;
          first_d = bus.din;
        end
      end
      if (inject && k == 10) bus.adc_valid = 1'b1;
      if (inject && k == 11) bus.adc_valid = 1'b0;
      @(negedge clk);
    end
    n_checks++;
    if (bad !== 0)
      $display("FAIL %s_burst_data: %0d bad beats, beat %0d add_rd=%0d din=%h, required add_rd=%0d din=%h",
               name, bad, first_k, first_a, first_d, first_k, exp_q[first_k]);
    else n_pass++;
    n_checks++;
    if ({bus.fft_load, bus.fft_start, bus.busy} !== 3'b011)
      $display("FAIL %s_start_entry: load/start/busy=%b, required 011", name, {bus.fft_load, bus.fft_start, bus.busy});
    else n_pass++;
  endtask

  task automatic release_start(input string name);
    bus.noted = 1'b1;
    @(negedge clk);
    bus.noted = 1'b0;
    n_checks++;
    if ({bus.fft_start, bus.busy} !== 2'b00)
      $display("FAIL %s_release: start/busy=%b, required 00", name, {bus.fft_start, bus.busy});
    else n_pass++;
  endtask

  task automatic check_overrun(input string name, input logic e);
    n_checks++;
    if (bus.overrun !== e) $display("FAIL %s_overrun: overrun=%b, required %b", name, bus.overrun, e);
    else n_pass++;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.fft_load, bus.fft_start, bus.busy, bus.overrun} !== 4'b0000 || bus.add_rd !== '0 || bus.din !== '0)
      $display("FAIL reset_outputs: load/start/busy/ovr=%b add_rd=%0d din=%h, required 0000 0 0000",
               {bus.fft_load, bus.fft_start, bus.busy, bus.overrun}, bus.add_rd, bus.din);
    else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_ramp;
    capture_ramp(32'h800);
    check_burst("ramp", 1'b0);
    check_overrun("ramp", 1'b0);
  endtask

  task automatic test_handshake;
    int bad;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.fft_start !== 1'b1 || bus.busy !== 1'b1) bad++;
      @(negedge clk);
    end
    n_checks++;
    if (bad !== 0) $display("FAIL handshake_hold: %0d cycles with start/busy low, required 0", bad);
    else n_pass++;
    release_start("handshake");
  endtask

  task automatic test_overrun;
    for (int k = 0; k < FS; k++) begin
      int d;
      d = (k == 0) ? 32'h000 : (k == 1) ? 32'h800 : (k == 2) ? 32'hFFF : (k * 5) & 32'hFFF;
      exp_q[k] = conv(d);
      send(d, 1'b1);
    end
    bus.noted = 1'b1;
    check_burst("overrun", 1'b1);
    @(negedge clk);
    bus.noted = 1'b0;
    n_checks++;
    if (bus.fft_start !== 1'b0) $display("FAIL noted_on_entry: fft_start=%b, required 0", bus.fft_start);
    else n_pass++;
    check_overrun("overrun_set", 1'b1);
  endtask

  task automatic test_next_frame;
    capture_ramp(32'h700);
    check_burst("next", 1'b0);
    release_start("next");
    check_overrun("overrun_sticky", 1'b1);
  endtask

  task automatic test_pause;
    int idx;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_overrun("after_reset", 1'b0);
    idx = 0;
    for (int k = 0; k < 200; k++) begin
      exp_q[idx] = conv((k * 7) & 32'hFFF);
      idx++;
      send((k * 7) & 32'hFFF, 1'b1);
    end
    for (int k = 0; k < 50; k++) send(32'hABC, 1'b0);
    for (int k = 200; k < FS; k++) begin
      exp_q[idx] = conv((k * 7) & 32'hFFF);
      idx++;
      send((k * 7) & 32'hFFF, 1'b1);
    end
    check_burst("pause", 1'b0);
    check_overrun("pause", 1'b0);
    release_start("pause");
  endtask

  task automatic test_reset_mid_burst;
    int wait_n, bad;
    capture_ramp(32'h900);
    wait_n = 0;
    while (!(bus.fft_load === 1'b1 && bus.add_rd === NW'(100)) && wait_n < 700) begin
      @(negedge clk);
      wait_n++;
    end
    n_checks++;
    if (wait_n >= 700) $display("FAIL midburst_reach: add_rd=%0d, required 100", bus.add_rd);
    else n_pass++;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if ({bus.fft_load, bus.fft_start, bus.busy} !== 3'b000 || bus.add_rd !== '0)
      $display("FAIL midburst_reset: load/start/busy=%b add_rd=%0d, required 000 0",
               {bus.fft_load, bus.fft_start, bus.busy}, bus.add_rd);
    else n_pass++;
    for (int k = 0; k < FS - 1; k++) begin
      exp_q[k] = conv(32'h600 + k);
      send(32'h600 + k, 1'b1);
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.fft_load !== 1'b0 || bus.busy !== 1'b0) bad++;
      @(negedge clk);
    end
    n_checks++;
    if (bad !== 0) $display("FAIL midburst_partial: %0d cycles loading on 511 samples, required 0", bad);
    else n_pass++;
    exp_q[FS-1] = conv(32'h600 + FS - 1);
    send(32'h600 + FS - 1, 1'b1);
    check_burst("fresh", 1'b0);
    release_start("fresh");
  endtask

  initial begin
    bus.en = 1'b0;
    bus.adc_valid = 1'b0;
    bus.adc_data = '0;
    bus.noted = 1'b0;
    test_reset();
    test_ramp();
    test_handshake();
    test_overrun();
    test_next_frame();
    test_pause();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/fft_frame_loader.md
Name: fft_frame_loader

Overview:
- Producer side of the fftfull load/start interface.
- Accepts a slow stream of unsigned ADC samples and converts each to signed fixed point.
- Buffers one full frame of FFT_SIZE samples, then bursts the frame into fftfull over fft_load/add_rd/din.
- Asserts fft_start and holds it until fftfull reports noted, then re-arms for the next frame.

Parameters:
- BIT_WIDTH, 16: width of din, signed two's complement.
- N, 9: address width; FFT_SIZE must equal 2**N.
- FFT_SIZE, 512: samples per frame.
- ADC_WIDTH, 12: width of the unsigned ADC sample. Must satisfy ADC_WIDTH <= BIT_WIDTH-1.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- en  input  1  capture enable; when low, no new frame starts.
- adc_valid  input  1  one-cycle strobe, adc_data valid.
- adc_data  input  ADC_WIDTH  unsigned sample, mid-scale = 2**(ADC_WIDTH-1).
- noted  input  1  fftfull done/note-detected; level.
- fft_load  output  1  load strobe to fftfull.
- add_rd  output  N  load address to fftfull.
- din  output  BIT_WIDTH  sample data to fftfull.
- fft_start  output  1  start request to fftfull; held high.
- busy  output  1  high in BURST or START.
- overrun  output  1  sticky; a sample was dropped.

Behaviour:
- Reset values: fft_load=0, add_rd=0, din=0, fft_start=0, busy=0, overrun=0. Write pointer=0, state=CAPTURE. RAM contents are not reset.
- Sample conversion, applied at write time:
  - s = adc_data - 2**(ADC_WIDTH-1), signed.
  - stored value = s << (BIT_WIDTH-ADC_WIDTH-1), in BIT_WIDTH bits.
  - Defaults give 0x800->0x0000, 0xFFF->0x3FF8, 0x000->0xC000.
- State CAPTURE:
  - Each adc_valid with en=1 writes the converted sample at wptr, then wptr++.
  - A write at wptr=FFT_SIZE-1 wraps wptr to 0 and moves to BURST on the next cycle.
  - adc_valid with en=0 is ignored and does not set overrun.
  - en deasserted mid-frame pauses capture; wptr is kept.
- State BURST:
  - Synchronous-read RAM with 1-cycle latency. Read address and data are pipelined so add_rd and din are registered and aligned on the same cycle.
  - fft_load is high for exactly FFT_SIZE consecutive cycles.
  - add_rd runs 0,1,...,FFT_SIZE-1, and din equals frame sample add_rd on each cycle.
  - There are no gaps and no repeats.
- State START:
  - Entered on the cycle after the final load beat; on that cycle fft_load=0 and fft_start=1.
  - fft_start stays high while noted=0.
  - The first cycle noted=1 is sampled: fft_start drops on the next edge, and the state moves to CAPTURE with wptr=0.
- Dropped samples: any adc_valid during BURST or START is dropped and sets overrun. overrun clears only on reset.
- Simultaneous events:
  - adc_valid on the same cycle CAPTURE moves to BURST is dropped and flagged.
  - noted=1 already high on entry to START still yields at least one cycle of fft_start=1.
- Reset mid-BURST or mid-START: all outputs return to reset values on the next edge; the partial frame is discarded.
- busy = (state==BURST || state==START), registered.

Decomposition:
- fft_pkg holds BIT_WIDTH, N, FFT_SIZE, ADC_WIDTH defaults and the typedef enum {CAPTURE, BURST, START} loader_state_t.
- One sub-module: frame_ram, a simple dual-port FFT_SIZE x BIT_WIDTH RAM with a synchronous write port and a synchronous read port of 1-cycle latency, inferable as BRAM.
- FSM, pointers and conversion stay in fft_frame_loader.

Test Plan:
- Ramp frame: 512 adc_valid strobes with adc_data=0x800+k (k=0..511) -> one burst of 512 consecutive fft_load cycles, add_rd=k, din=k<<3 (0x0000,0x0008,...,0x0FF8). fft_start rises the cycle after add_rd=511.
- Conversion extremes: adc_data 0x000, 0x800, 0xFFF at addresses 0..2 -> din 0xC000, 0x0000, 0x3FF8.
- Handshake: hold noted=0 for 100 cycles after the burst -> fft_start stays 1 and busy=1. Pulse noted=1 -> fft_start=0 next edge, and the next capture writes to address 0.
- Overrun: issue adc_valid during BURST -> overrun=1 and stays set. Loaded frame data is unchanged, and the next frame starts at address 0.
- Pause: en=0 after 200 samples, 50 strobes ignored, en=1 for 312 more -> burst contains exactly samples 0..511 of the enabled strobes. overrun=0.
- Reset mid-BURST at add_rd=100 -> next edge fft_load=0, add_rd=0, fft_start=0, busy=0. A fresh 512-sample capture is required before the next burst.
